// File: rtl/ifetch_stage.sv
// ifetch_stage: owns the PC, issues instruction ROM reads and queues {pc, instr} toward decode
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_AW = 12,
  parameter int QDEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_ena,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [31:0]        out_pc,
  output logic               out_misalign
);
  localparam int QAW = $clog2(QDEPTH);
  logic [31:0] pc_q, resp_pc_q, tgt;
  logic inflight_q, resp_mis_q, pop, push, issue;
  logic [31:0] q_pc [QDEPTH];
  logic [31:0] q_instr [QDEPTH];
  logic [QDEPTH-1:0] q_mis;
  logic [QAW-1:0] rd_q, wr_q;
  logic [QAW:0] count_q, occ;
  assign tgt = {redirect_pc[31:2], 2'b00};
  assign out_valid = (count_q != '0) & !redirect_valid;
  assign pop = out_valid & out_ready;
  assign push = inflight_q & !redirect_valid;
  // credits cover both queued entries and the read still in the ROM pipeline
  assign occ = count_q + {{QAW{1'b0}}, inflight_q};
  assign issue = (occ < (QAW+1)'(QDEPTH)) | ((occ == (QAW+1)'(QDEPTH)) & pop);
  assign imem_ena = rst_n & (redirect_valid | issue);
  assign imem_addr = redirect_valid ? tgt[IMEM_AW-1:0] : pc_q[IMEM_AW-1:0];
  assign out_pc = q_pc[rd_q];
  assign out_instr = q_instr[rd_q];
  assign out_misalign = q_mis[rd_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      resp_pc_q <= '0;
      resp_mis_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else if (redirect_valid) begin
      pc_q <= tgt + 32'd4;
      inflight_q <= 1'b1;
      resp_pc_q <= tgt;
      resp_mis_q <= |redirect_pc[1:0];
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q <= pc_q + 32'd4;
        resp_pc_q <= pc_q;
        resp_mis_q <= 1'b0;
      end
      rd_q <= rd_q + QAW'(pop);
      wr_q <= wr_q + QAW'(push);
      count_q <= count_q + (QAW+1)'(push) - (QAW+1)'(pop);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i] <= '0;
        q_instr[i] <= '0;
      end
      q_mis <= '0;
    end else if (push) begin
      q_pc[wr_q] <= resp_pc_q;
      q_instr[wr_q] <= imem_dout;
      q_mis[wr_q] <= resp_mis_q;
    end
  end
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: random and directed stimulus against a request-level model of the fetch stage
module tb_ifetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int IMEM_AW = 12;
  localparam int QDEPTH = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_ena, redirect_valid = 1'b0, out_valid, out_ready = 1'b1, out_misalign;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0] imem_dout = '0, redirect_pc = '0, out_instr, out_pc;
  logic [31:0] rom [1024];
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] fpc = RESET_PC;
  typedef struct { logic [31:0] pc; logic mis; int rdy; } ent_t;
  ent_t q[$];

  ifetch_stage #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ena(imem_ena), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_misalign(out_misalign));

  always #5 clk = ~clk;
  always @(posedge clk) imem_dout <= imem_ena ? rom[imem_addr[IMEM_AW-1:2]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // outstanding requests in issue order; an entry becomes visible two cycles after issue
  task automatic model();
    logic ev, pop, eena;
    logic [31:0] tgt;
    if (!rst_n) begin
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_ena", 32'(imem_ena), 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_instr", out_instr, 0);
      chk("rst_mis", 32'(out_misalign), 0);
      q.delete();
      fpc = RESET_PC;
    end else if (redirect_valid) begin
      tgt = {redirect_pc[31:2], 2'b00};
      chk("redir_valid", 32'(out_valid), 0);
      chk("redir_ena", 32'(imem_ena), 1);
      chk("redir_addr", 32'(imem_addr), 32'(tgt[IMEM_AW-1:0]));
      q.delete();
      q.push_back('{tgt, redirect_pc[1:0] != 2'b00, cyc + 2});
      fpc = tgt + 32'd4;
    end else begin
      ev = q.size() > 0 && q[0].rdy <= cyc;
      pop = ev & out_ready;
      eena = q.size() < QDEPTH || (q.size() == QDEPTH && pop);
      chk("valid", 32'(out_valid), 32'(ev));
      chk("ena", 32'(imem_ena), 32'(eena));
      if (eena) chk("addr", 32'(imem_addr), 32'(fpc[IMEM_AW-1:0]));
      if (ev) begin
        chk("pc", out_pc, q[0].pc);
        chk("instr", out_instr, rom[q[0].pc[IMEM_AW-1:2]]);
        chk("mis", 32'(out_misalign), 32'(q[0].mis));
      end
      if (pop) void'(q.pop_front());
      if (eena) begin
        q.push_back('{fpc, 1'b0, cyc + 2});
        fpc = fpc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic cycle(input logic rn, input logic r, input logic rv, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst_n = rn;
    out_ready = r;
    redirect_valid = rv;
    redirect_pc = rp;
    @(negedge clk);
    model();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0] = 32'h0050_0093;
    rom[1] = 32'h00A0_0113;
    rom[2] = 32'h0020_81B3;
    #2;
    chk("lit_rst_valid", 32'(out_valid), 0);
    chk("lit_rst_ena", 32'(imem_ena), 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("lit_c0_addr", 32'(imem_addr), 0);
    cycle(1, 1, 0, 0);
    chk("lit_c1_addr", 32'(imem_addr), 4);
    cycle(1, 1, 0, 0);
    chk("lit_c2_addr", 32'(imem_addr), 8);
    chk("lit_c2_pc", out_pc, 0);
    chk("lit_c2_instr", out_instr, 32'h0050_0093);
    cycle(1, 1, 0, 0);
    chk("lit_c3_instr", out_instr, 32'h00A0_0113);
    cycle(1, 1, 0, 0);
    chk("lit_c4_pc", out_pc, 8);
    chk("lit_c4_instr", out_instr, 32'h0020_81B3);
    for (int i = 5; i <= 10; i++) cycle(1, 0, 0, 0);
    chk("lit_stall_ena", 32'(imem_ena), 0);
    chk("lit_stall_pc", out_pc, 32'hC);
    cycle(1, 1, 0, 0);
    chk("lit_rel_pc0", out_pc, 32'hC);
    cycle(1, 1, 0, 0);
    chk("lit_rel_pc1", out_pc, 32'h10);
    cycle(1, 1, 1, 32'h40);
    chk("lit_redir_valid", 32'(out_valid), 0);
    cycle(1, 1, 0, 0);
    chk("lit_redir_valid1", 32'(out_valid), 0);
    cycle(1, 1, 0, 0);
    chk("lit_redir_pc", out_pc, 32'h40);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 32'h42);
    chk("lit_mis_addr", 32'(imem_addr), 32'h40);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("lit_mis_pc", out_pc, 32'h40);
    chk("lit_mis_flag", 32'(out_misalign), 1);
    cycle(1, 1, 0, 0);
    chk("lit_mis_next", out_pc, 32'h44);
    chk("lit_mis_next_flag", 32'(out_misalign), 0);
    cycle(1, 1, 1, 32'hFFC);
    chk("lit_wrap_addr0", 32'(imem_addr), 32'hFFC);
    cycle(1, 1, 0, 0);
    chk("lit_wrap_addr1", 32'(imem_addr), 0);
    cycle(1, 1, 0, 0);
    chk("lit_wrap_pc0", out_pc, 32'hFFC);
    cycle(1, 1, 0, 0);
    chk("lit_wrap_pc1", out_pc, 32'h1000);
    chk("lit_wrap_instr", out_instr, 32'h0050_0093);
    for (int i = 0; i < 3000; i++)
      cycle(1, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("lit_async_valid", 32'(out_valid), 0);
    chk("lit_async_ena", 32'(imem_ena), 0);
    @(negedge clk);
    model();
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("lit_rel_addr", 32'(imem_addr), 32'(RESET_PC[IMEM_AW-1:0]));
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("lit_rel_out_pc", out_pc, RESET_PC);
    chk("lit_rel_out_valid", 32'(out_valid), 1);
    for (int i = 0; i < 500; i++)
      cycle(1, $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0, $urandom);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
